// File: rtl/seg_pkg.sv
// Shared types and constants for the memory-mapped 7-segment display peripheral.
// Segment patterns are active-high in {G,F,E,D,C,B,A} order. The parent module applies the board polarity.
package seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [31:0] REG_DATA_OFS = 32'd0;
    localparam logic [31:0] REG_CTRL_OFS = 32'd4;

    localparam int CTRL_BLANK_LSB  = 0;
    localparam int CTRL_LED_LSB    = 8;
    localparam int CTRL_LED_W      = 4;
    localparam int CTRL_BRIGHT_LSB = 16;

endpackage

// File: rtl/seg_hex_decode.sv
// Registered decoder that converts a nibble to an active-high seg_t pattern.
// A blanked digit decodes to all segments off.
module seg_hex_decode import seg_pkg::*; (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    seg_t seg_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            seg_reg <= '0;
        end else if (blank) begin
            seg_reg <= '0;
        end else begin
            seg_reg <= HEX_SEG[nibble];
        end
    end

    assign seg = seg_reg;

endmodule

// File: rtl/mmio_seg_display.sv
// Display peripheral on the CPU data bus. It has DATA/CTRL store registers, N hex digits and 4 LEDs with PWM dimming.
// When SEG_SCAN_EN is defined, the digits are time-multiplexed. Otherwise every digit is driven in parallel (static mode).
module mmio_seg_display import seg_pkg::*; #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0014,
    parameter int          NUM_DIGITS     = 2,
    parameter int          SEG_ACTIVE_LOW = 1,
    parameter int          PWM_BITS       = 4,
    parameter int          SCAN_DIV       = 12000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ce_i,
    input  logic                    mem_write_i,
    input  logic [31:0]             addr_i,
    input  logic [31:0]             wdata_i,
    output logic [NUM_DIGITS*7-1:0] seg_o,
    output logic [NUM_DIGITS-1:0]   dig_en_o,
    output logic [3:0]              led_o
);

    logic                    bus_wr;
    logic                    data_hit;
    logic                    ctrl_hit;
    logic [4*NUM_DIGITS-1:0] data_reg;
    logic [NUM_DIGITS-1:0]   blank_reg;
    logic [3:0]              led_val_reg;
    logic [PWM_BITS-1:0]     bright_reg;
    logic [PWM_BITS-1:0]     pwm_cnt_reg;
    logic [3:0]              led_reg;
    logic [NUM_DIGITS-1:0]   dig_en_reg;
    logic [NUM_DIGITS*7-1:0] seg_hi;
    logic                    unused_wdata;

    // Exact 32-bit match, so misaligned byte addresses never alias onto a register.
    assign bus_wr   = ce_i && mem_write_i;
    assign data_hit = bus_wr && (addr_i == BASE_ADDR + REG_DATA_OFS);
    assign ctrl_hit = bus_wr && (addr_i == BASE_ADDR + REG_CTRL_OFS);

    assign unused_wdata = ^wdata_i;

    always_ff @(posedge clk) begin
        if (!reset) begin
            data_reg    <= '0;
            blank_reg   <= '0;
            led_val_reg <= '0;
            bright_reg  <= '0;
        end else begin
            if (data_hit) begin
                data_reg <= wdata_i[4*NUM_DIGITS-1:0];
            end
            if (ctrl_hit) begin
                blank_reg   <= wdata_i[CTRL_BLANK_LSB +: NUM_DIGITS];
                led_val_reg <= wdata_i[CTRL_LED_LSB +: CTRL_LED_W];
                bright_reg  <= wdata_i[CTRL_BRIGHT_LSB +: PWM_BITS];
            end
        end
    end

    // Free-running PWM counter. Duty equals bright / 2^PWM_BITS over every period.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pwm_cnt_reg <= '0;
            led_reg     <= '0;
        end else begin
            pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
            led_reg     <= led_val_reg & {4{pwm_cnt_reg < bright_reg}};
        end
    end

    assign led_o = led_reg;

`ifdef SEG_SCAN_EN
    localparam int TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [TICK_W-1:0]     tick_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic [NUM_DIGITS-1:0] dig_en_next;
    logic [6:0]            scan_seg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_reg <= '0;
            idx_reg  <= '0;
        end else if (tick_reg == TICK_W'(SCAN_DIV - 1)) begin
            tick_reg <= '0;
            idx_reg  <= (idx_reg == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_reg + 1'b1;
        end else begin
            tick_reg <= tick_reg + 1'b1;
        end
    end

    always_comb begin
        dig_en_next          = '0;
        dig_en_next[idx_reg] = ~blank_reg[idx_reg];
    end

    // The enable is registered alongside the decoder, so the pattern and the enable stay in the same slot.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dig_en_reg <= '0;
        end else begin
            dig_en_reg <= dig_en_next;
        end
    end

    seg_hex_decode u_dec (
        .clk    (clk),
        .reset  (reset),
        .nibble (data_reg[4*idx_reg +: 4]),
        .blank  (blank_reg[idx_reg]),
        .seg    (scan_seg)
    );

    assign seg_hi = {NUM_DIGITS{scan_seg}};
`else
    localparam int unused_scan_div = SCAN_DIV;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dec
        seg_hex_decode u_dec (
            .clk    (clk),
            .reset  (reset),
            .nibble (data_reg[4*gi +: 4]),
            .blank  (blank_reg[gi]),
            .seg    (seg_hi[7*gi +: 7])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            dig_en_reg <= '0;
        end else begin
            dig_en_reg <= ~blank_reg;
        end
    end
`endif

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_pol
        assign seg_o[7*gi +: 7] = (SEG_ACTIVE_LOW != 0) ? ~seg_hi[7*gi +: 7] : seg_hi[7*gi +: 7];
    end

    assign dig_en_o = dig_en_reg;

endmodule

// File: tb/tb_mmio_seg_display.sv
// Directed bench for mmio_seg_display. Expected display values are queued when stimulus is driven and checked one edge later.
// With SEG_SCAN_EN defined it exercises scan mode with 4 digits and SCAN_DIV=3.
`timescale 1ns/1ps
module tb_mmio_seg_display;

`ifdef SEG_SCAN_EN
    localparam int ND   = 4;
    localparam int SDIV = 3;
`else
    localparam int ND   = 2;
    localparam int SDIV = 12000;
`endif
    localparam logic [31:0] BASE = 32'h0000_0014;

    // Active-low {G,F,E,D,C,B,A} patterns for 0..F.
    localparam logic [6:0] HEX_LO [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            ce_i = 1'b0;
    logic            mem_write_i = 1'b0;
    logic [31:0]     addr_i = '0;
    logic [31:0]     wdata_i = '0;
    logic [ND*7-1:0] seg_o;
    logic [ND-1:0]   dig_en_o;
    logic [3:0]      led_o;

    mmio_seg_display #(
        .BASE_ADDR      (BASE),
        .NUM_DIGITS     (ND),
        .SEG_ACTIVE_LOW (1),
        .PWM_BITS       (4),
        .SCAN_DIV       (SDIV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ce_i        (ce_i),
        .mem_write_i (mem_write_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .seg_o       (seg_o),
        .dig_en_o    (dig_en_o),
        .led_o       (led_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           tag;
        logic [ND*7-1:0] seg;
        logic [ND-1:0]   en;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_data = '0;
    logic [7:0]  m_blank = '0;
    int          led_cnt [4];
    int          edge_k = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [ND*7-1:0] exp_seg();
        logic [ND*7-1:0] r;
        for (int i = 0; i < ND; i++) begin
            r[7*i +: 7] = m_blank[i] ? 7'h7F : HEX_LO[m_data[4*i +: 4]];
        end
        return r;
    endfunction

    function automatic logic [ND*7-1:0] rep(input logic [6:0] p);
        logic [ND*7-1:0] r;
        for (int i = 0; i < ND; i++) begin
            r[7*i +: 7] = p;
        end
        return r;
    endfunction

    task automatic push_exp(input string tag, input logic [ND*7-1:0] s, input logic [ND-1:0] e);
        exp_t x;
        x.tag = tag;
        x.seg = s;
        x.en  = e;
        sb.push_back(x);
    endtask

    task automatic pop_check();
        exp_t x;
        n_cmp++;
        assert (sb.size() != 0) else begin
            n_bad++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end
        if (sb.size() != 0) begin
            x = sb.pop_front();
            check({x.tag, "_seg"}, 64'(seg_o), 64'(x.seg));
            check({x.tag, "_en"}, 64'(dig_en_o), 64'(x.en));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_k++;
    endtask

    // Drive one store for cyc cycles. The model is updated, and the display is checked on the following edge.
    task automatic store(input string tag, input logic [31:0] a, input logic [31:0] d,
                         input logic c, input int cyc);
        ce_i        = c;
        mem_write_i = 1'b1;
        addr_i      = a;
        wdata_i     = d;
        repeat (cyc) step();
        mem_write_i = 1'b0;
        ce_i        = 1'b1;
        if (c) begin
            if (a == BASE) m_data = d;
            else if (a == BASE + 32'd4) m_blank = d[7:0];
        end
        push_exp(tag, exp_seg(), ~m_blank[ND-1:0]);
        step();
        pop_check();
    endtask

    task automatic count_leds();
        for (int b = 0; b < 4; b++) led_cnt[b] = 0;
        for (int c = 0; c < 16; c++) begin
            step();
            for (int b = 0; b < 4; b++) led_cnt[b] += int'(led_o[b]);
        end
    endtask

    initial begin
        repeat (5) step();
        check("reset_seg", 64'(seg_o), 64'(rep(7'h7F)));
        check("reset_en", 64'(dig_en_o), 64'd0);
        check("reset_led", 64'(led_o), 64'd0);
        reset  = 1'b1;
        edge_k = 0;

`ifdef SEG_SCAN_EN
        for (int k = 1; k <= 13; k++) begin
            step();
            check($sformatf("scan_en_%0d", k), 64'(dig_en_o), 64'(4'b0001 << (((k - 1) / 3) % 4)));
            check($sformatf("scan_seg_%0d", k), 64'(seg_o), 64'(rep(HEX_LO[0])));
        end
        ce_i        = 1'b1;
        mem_write_i = 1'b1;
        addr_i      = BASE;
        wdata_i     = 32'h0000_4321;
        step();
        addr_i      = BASE + 32'd4;
        wdata_i     = 32'h0000_0004;
        step();
        mem_write_i = 1'b0;
        m_data      = 32'h0000_4321;
        m_blank     = 8'h04;
        step();
        begin
            int zeros;
            int idx;
            zeros = 0;
            for (int c = 0; c < 24; c++) begin
                idx = ((edge_k) / 3) % 4;
                push_exp($sformatf("scan_slot_%0d", c),
                         rep(m_blank[idx] ? 7'h7F : HEX_LO[m_data[4*idx +: 4]]),
                         m_blank[idx] ? 4'b0000 : 4'(4'b0001 << idx));
                step();
                pop_check();
                if (dig_en_o == '0) zeros++;
            end
            check("scan_blank_slots", 64'(zeros), 64'd6);
        end
`else
        push_exp("release", exp_seg(), 2'b11);
        step();
        pop_check();

        store("data_a5", BASE, 32'h0000_00A5, 1'b1, 1);
        check("a5_group0", 64'(seg_o[6:0]), 64'(7'b0010010));
        check("a5_group1", 64'(seg_o[13:7]), 64'(7'b0001000));
        store("ce_low", BASE, 32'h0000_0033, 1'b0, 1);
        store("addr_15", 32'h0000_0015, 32'h0000_0033, 1'b1, 1);
        store("addr_10", 32'h0000_0010, 32'h0000_0033, 1'b1, 1);
        store("addr_16", 32'h0000_0016, 32'h0000_0033, 1'b1, 1);
        store("held", BASE, 32'h0000_003C, 1'b1, 3);
        store("high_bits", BASE, 32'hFFFF_FF12, 1'b1, 1);

        store("ctrl_blank", BASE + 32'd4, 32'h000F_0A02, 1'b1, 1);
        check("blank_group1", 64'(seg_o[13:7]), 64'(7'h7F));
        count_leds();
        check("led0_f", 64'(led_cnt[0]), 64'd0);
        check("led1_f", 64'(led_cnt[1]), 64'd15);
        check("led2_f", 64'(led_cnt[2]), 64'd0);
        check("led3_f", 64'(led_cnt[3]), 64'd15);

        store("ctrl_b0", BASE + 32'd4, 32'h0000_0F00, 1'b1, 1);
        count_leds();
        check("b0_led", 64'(led_cnt[0] + led_cnt[1] + led_cnt[2] + led_cnt[3]), 64'd0);

        store("ctrl_b4", BASE + 32'd4, 32'h0004_0F00, 1'b1, 1);
        for (int w = 0; w < 10; w++) begin
            count_leds();
            check($sformatf("b4_led0_w%0d", w), 64'(led_cnt[0]), 64'd4);
            check($sformatf("b4_led3_w%0d", w), 64'(led_cnt[3]), 64'd4);
        end

        // Stream of stores with reset asserted in the middle.
        ce_i        = 1'b1;
        mem_write_i = 1'b1;
        addr_i      = BASE;
        wdata_i     = 32'h0000_0077;
        step();
        addr_i      = BASE + 32'd4;
        wdata_i     = 32'h000F_0F01;
        step();
        reset       = 1'b0;
        addr_i      = BASE;
        wdata_i     = 32'h0000_0099;
        step();
        check("midrst_seg", 64'(seg_o), 64'(rep(7'h7F)));
        check("midrst_en", 64'(dig_en_o), 64'd0);
        check("midrst_led", 64'(led_o), 64'd0);
        addr_i      = BASE + 32'd4;
        wdata_i     = 32'h000F_0F03;
        step();
        addr_i      = BASE;
        wdata_i     = 32'h0000_00EE;
        step();
        mem_write_i = 1'b0;
        reset       = 1'b1;
        m_data      = '0;
        m_blank     = '0;
        push_exp("post_reset", exp_seg(), 2'b11);
        step();
        pop_check();
        count_leds();
        check("post_reset_led", 64'(led_cnt[0] + led_cnt[1] + led_cnt[2] + led_cnt[3]), 64'd0);
`endif

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
